jtag_vdr_bank: RTL and testbench

Parametrised virtual-JTAG data-register bank, successor to the fixed seven-register audio VDR. Sits between the virtual JTAG TAP and fabric logic. Decodes the TAP's IR into an IDENT register, an auto-incrementing ADDR register, a STATUS register, and NUM_REGS generic data registers, with BYPASS for every other opcode. Adds scan-length checking with a sticky error flag, per-register update strobes, and address auto-increment for burst access.

---
 rtl/jtag_vdr_bank_pkg.sv | 34 +++
 rtl/jtag_vdr_shifter.sv | 52 +++++
 rtl/jtag_vdr_bank.sv | 162 ++++++++++++++++
 tb/tb_jtag_vdr_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_vdr_bank_pkg.sv
// Shared opcode map and selection decode for the virtual-JTAG data-register bank.
package jtag_vdr_bank_pkg;

    localparam int IIDENT  = 0;
    localparam int IADDR   = 1;
    localparam int ISTATUS = 2;
    localparam int IDATA0  = 3;

    typedef enum logic [2:0] {
        SEL_IDENT  = 3'd0,
        SEL_ADDR   = 3'd1,
        SEL_STATUS = 3'd2,
        SEL_DATA   = 3'd3,
        SEL_BYPASS = 3'd4
    } sel_kind_e;

    // Unmapped opcodes, including data slots beyond num_regs, fall back to BYPASS.
    function automatic sel_kind_e decode_op(input int op, input int num_regs);
        sel_kind_e kind;
        if (op == IIDENT) begin
            kind = SEL_IDENT;
        end else if (op == IADDR) begin
            kind = SEL_ADDR;
        end else if (op == ISTATUS) begin
            kind = SEL_STATUS;
        end else if ((op >= IDATA0) && (op < IDATA0 + num_regs)) begin
            kind = SEL_DATA;
        end else begin
            kind = SEL_BYPASS;
        end
        return kind;
    endfunction

endpackage

// File: rtl/jtag_vdr_shifter.sv
// Capture/shift register with a saturating shift counter that qualifies updates
// by exact scan length.
module jtag_vdr_shifter #(
    parameter int DR_LENGTH = 24
) (
    input  logic                 tck,
    input  logic                 reset_n,
    input  logic                 tdi,
    input  logic                 capture,
    input  logic                 shift,
    input  logic [DR_LENGTH-1:0] cap_value,
    output logic [DR_LENGTH-1:0] sr,
    output logic                 length_ok
);

    localparam int CNT_W = $clog2(DR_LENGTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_LENGTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_LENGTH + 1);

    logic [DR_LENGTH-1:0] sr_r;
    logic [CNT_W-1:0]     cnt_r;

    // Shift register: capture has priority over a coincident shift.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            sr_r <= '0;
        end else if (capture) begin
            sr_r <= cap_value;
        end else if (shift) begin
            sr_r <= {tdi, sr_r[DR_LENGTH-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    // Counter sticks one past full so long scans can never wrap back to a legal length.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (capture) begin
            cnt_r <= '0;
        end else if (shift && (cnt_r != CNT_SAT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sr        = sr_r;
    assign length_ok = (cnt_r == CNT_FULL);

endmodule

// File: rtl/jtag_vdr_bank.sv
// Virtual-JTAG data-register bank: IDENT, auto-incrementing ADDR, STATUS and
// NUM_REGS generic registers, with length-checked updates and per-register strobes.
module jtag_vdr_bank
    import jtag_vdr_bank_pkg::*;
#(
    parameter int                   IR_LENGTH    = 4,
    parameter int                   DR_LENGTH    = 24,
    parameter int                   NUM_REGS     = 8,
    parameter logic [DR_LENGTH-1:0] IDENT_VALUE  = 24'h4A5447,
    parameter logic [NUM_REGS-1:0]  AUTOINC_MASK = {NUM_REGS{1'b1}}
) (
    input  logic                          tck,
    input  logic                          reset_n,
    input  logic                          tdi,
    output logic                          tdo,
    input  logic [IR_LENGTH-1:0]          ir,
    input  logic                          capture_dr,
    input  logic                          shift_dr,
    input  logic                          update_dr,
    input  logic [NUM_REGS*DR_LENGTH-1:0] cap_data_in,
    output logic [NUM_REGS*DR_LENGTH-1:0] upd_data_out,
    output logic [NUM_REGS-1:0]           upd_strobe,
    output logic [DR_LENGTH-1:0]          addr_out,
    output logic                          len_err
);

    logic [IR_LENGTH-1:0]                 sel_r;
    logic                                 byp_r;
    logic [DR_LENGTH-1:0]                 addr_r;
    logic                                 len_err_r;
    logic [NUM_REGS-1:0]                  strobe_r;
    logic [NUM_REGS-1:0][DR_LENGTH-1:0]   data_r;

    sel_kind_e            cap_kind_s;
    sel_kind_e            cur_kind_s;
    logic [NUM_REGS-1:0]  cap_hit_s;
    logic [NUM_REGS-1:0]  cur_hit_s;
    logic [DR_LENGTH-1:0] cap_value_s;
    logic [DR_LENGTH-1:0] sr_s;
    logic                 length_ok_s;
    logic                 check_s;
    logic [NUM_REGS-1:0]  wr_en_s;
    logic [DR_LENGTH-1:0] addr_nxt_s;
    logic                 len_err_nxt_s;

    jtag_vdr_shifter #(
        .DR_LENGTH (DR_LENGTH)
    ) u_shifter (
        .tck       (tck),
        .reset_n   (reset_n),
        .tdi       (tdi),
        .capture   (capture_dr),
        .shift     (shift_dr),
        .cap_value (cap_value_s),
        .sr        (sr_s),
        .length_ok (length_ok_s)
    );

    // Decode: live ir steers the capture mux, the latched selection governs shift and update.
    always_comb begin
        cap_kind_s = decode_op(int'(ir), NUM_REGS);
        cur_kind_s = decode_op(int'(sel_r), NUM_REGS);
        for (int k = 0; k < NUM_REGS; k++) begin
            cap_hit_s[k] = (int'(ir) == IDATA0 + k);
            cur_hit_s[k] = (int'(sel_r) == IDATA0 + k);
        end
    end

    // Capture value mux.
    always_comb begin
        cap_value_s = '0;
        case (cap_kind_s)
            SEL_IDENT:  cap_value_s = IDENT_VALUE;
            SEL_ADDR:   cap_value_s = addr_r;
            SEL_STATUS: cap_value_s = {{(DR_LENGTH-1){1'b0}}, len_err_r};
            SEL_DATA: begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    cap_value_s = cap_value_s |
                        (cap_hit_s[k] ? cap_data_in[k*DR_LENGTH +: DR_LENGTH] : {DR_LENGTH{1'b0}});
                end
            end
            default:    cap_value_s = '0;
        endcase
    end

    // Update decision: a wrong-length scan only raises len_err and changes nothing else.
    always_comb begin
        check_s       = update_dr && ((cur_kind_s == SEL_ADDR) ||
                                      (cur_kind_s == SEL_STATUS) ||
                                      (cur_kind_s == SEL_DATA));
        wr_en_s       = '0;
        addr_nxt_s    = addr_r;
        len_err_nxt_s = len_err_r;
        if (check_s && !length_ok_s) begin
            len_err_nxt_s = 1'b1;
        end else if (check_s) begin
            case (cur_kind_s)
                SEL_ADDR:   addr_nxt_s = sr_s;
                SEL_STATUS: len_err_nxt_s = sr_s[0] ? 1'b0 : len_err_r;
                SEL_DATA: begin
                    wr_en_s    = cur_hit_s;
                    addr_nxt_s = (|(cur_hit_s & AUTOINC_MASK)) ? addr_r + DR_LENGTH'(1) : addr_r;
                end
                default:    addr_nxt_s = addr_r;
            endcase
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // Selection latch and the one-bit bypass register.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            sel_r <= '0;
            byp_r <= 1'b0;
        end else if (capture_dr) begin
            sel_r <= ir;
            byp_r <= 1'b0;
        end else if (shift_dr && (cur_kind_s == SEL_BYPASS)) begin
            sel_r <= sel_r;
            byp_r <= tdi;
        end else begin
            sel_r <= sel_r;
            byp_r <= byp_r;
        end
    end

    // ADDR, sticky error and strobes; the strobe is high for the cycle after the update edge.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            addr_r    <= '0;
            len_err_r <= 1'b0;
            strobe_r  <= '0;
        end else begin
            addr_r    <= addr_nxt_s;
            len_err_r <= len_err_nxt_s;
            strobe_r  <= wr_en_s;
        end
    end

    // Generic data register file.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en_s[k]) begin
                    data_r[k] <= sr_s;
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    assign tdo          = (cur_kind_s == SEL_BYPASS) ? byp_r : sr_s[0];
    assign upd_data_out = data_r;
    assign upd_strobe   = strobe_r;
    assign addr_out     = addr_r;
    assign len_err      = len_err_r;

endmodule

// File: tb/tb_jtag_vdr_bank.sv
// Self-checking bench for jtag_vdr_bank: directed vector table, corner-case
// sequences, then random scans against a scan-level reference model.
module tb_jtag_vdr_bank;

    localparam int IRL = 4;
    localparam int DRL = 24;
    localparam int NR  = 8;

    logic              tck = 1'b0;
    logic              reset_n;
    logic              tdi;
    logic              tdo;
    logic [IRL-1:0]    ir;
    logic              capture_dr;
    logic              shift_dr;
    logic              update_dr;
    logic [NR*DRL-1:0] cap_data_in;
    logic [NR*DRL-1:0] upd_data_out;
    logic [NR-1:0]     upd_strobe;
    logic [DRL-1:0]    addr_out;
    logic              len_err;

    int checks   = 0;
    int failures = 0;

    always #5 tck = ~tck;

    jtag_vdr_bank #(
        .IR_LENGTH   (IRL),
        .DR_LENGTH   (DRL),
        .NUM_REGS    (NR),
        .IDENT_VALUE (24'h4A5447)
    ) dut (
        .tck          (tck),
        .reset_n      (reset_n),
        .tdi          (tdi),
        .tdo          (tdo),
        .ir           (ir),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .cap_data_in  (cap_data_in),
        .upd_data_out (upd_data_out),
        .upd_strobe   (upd_strobe),
        .addr_out     (addr_out),
        .len_err      (len_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  ir_mid;
        logic [31:0] din;
        int          nbits;
        bit          upd;
        logic [31:0] exp_tdo;
        logic [23:0] exp_addr;
        logic        exp_err;
        logic [7:0]  exp_stb;
    } vec_t;

    vec_t vt[11];

    // Reference model state.
    logic [DRL-1:0] m_addr;
    logic           m_err;
    logic [DRL-1:0] m_data[NR];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        @(negedge tck);
    endtask

    // One complete DR scan; ir is switched to ir_mid right after capture.
    task automatic scan(input logic [3:0] op, input logic [3:0] ir_mid, input logic [63:0] din,
                        input int nbits, input bit upd,
                        output logic [63:0] dout, output logic [NR-1:0] stb);
        ir = op;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        ir = ir_mid;
        dout = '0;
        shift_dr = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tdi = din[i];
            dout[i] = tdo;
            step();
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
        stb = '0;
        if (upd) begin
            update_dr = 1'b1;
            step();
            update_dr = 1'b0;
            stb = upd_strobe;
        end
        step();
        check("strobe_one_cycle", 256'(upd_strobe), 256'(0));
    endtask

    // Scan-level model: capture value, output stream and update effects from the opcode rules.
    task automatic model_scan(input logic [3:0] op, input logic [63:0] din, input int nbits,
                              input bit upd, output logic [63:0] exp_out, output logic [NR-1:0] exp_stb);
        int          o;
        bit          is_byp;
        logic [23:0] cap;
        o = int'(op);
        is_byp = !(o <= 2 || (o >= 3 && o < 3 + NR));
        cap = 24'h0;
        if (o == 0) cap = 24'h4A5447;
        else if (o == 1) cap = m_addr;
        else if (o == 2) cap = {23'h0, m_err};
        else if (!is_byp) cap = cap_data_in[(o-3)*DRL +: DRL];
        exp_out = '0;
        for (int i = 0; i < nbits; i++) begin
            if (is_byp) exp_out[i] = (i == 0) ? 1'b0 : din[i-1];
            else        exp_out[i] = (i < DRL) ? cap[i] : din[i-DRL];
        end
        exp_stb = '0;
        if (upd && !is_byp && o != 0) begin
            if (nbits != DRL) begin
                m_err = 1'b1;
            end else if (o == 1) begin
                m_addr = din[23:0];
            end else if (o == 2) begin
                if (din[0]) m_err = 1'b0;
            end else begin
                m_data[o-3] = din[23:0];
                exp_stb[o-3] = 1'b1;
                m_addr = m_addr + 24'd1;
            end
        end
    endtask

    initial begin
        logic [63:0]     dout;
        logic [NR-1:0]   stb;
        logic [63:0]     eout;
        logic [NR-1:0]   estb;
        logic [NR*DRL-1:0] edata;
        logic [3:0]      op;
        logic [3:0]      mid;
        logic [63:0]     din;
        int              nb;
        int              r;
        bit              upd;

        reset_n = 1'b0; tdi = 1'b0; ir = '0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        for (int k = 0; k < NR; k++) cap_data_in[k*DRL +: DRL] = {8'(k + 1), 16'hC0DE};

        vt[0]  = '{4'd0,  4'd0, 32'h000000, 24, 1'b1, 32'h4A5447, 24'h000000, 1'b0, 8'h00};
        vt[1]  = '{4'd1,  4'd1, 32'h000010, 24, 1'b1, 32'h000000, 24'h000010, 1'b0, 8'h00};
        vt[2]  = '{4'd5,  4'd5, 32'h0000A1, 24, 1'b1, 32'h03C0DE, 24'h000011, 1'b0, 8'h04};
        vt[3]  = '{4'd5,  4'd5, 32'h0000B2, 24, 1'b1, 32'h03C0DE, 24'h000012, 1'b0, 8'h04};
        vt[4]  = '{4'd5,  4'd5, 32'h0000C3, 24, 1'b1, 32'h03C0DE, 24'h000013, 1'b0, 8'h04};
        vt[5]  = '{4'd8,  4'd8, 32'h5A5A5A, 23, 1'b1, 32'h06C0DE, 24'h000013, 1'b1, 8'h00};
        vt[6]  = '{4'd2,  4'd2, 32'h000001, 24, 1'b1, 32'h000001, 24'h000013, 1'b0, 8'h00};
        vt[7]  = '{4'd1,  4'd1, 32'hFFFFFF, 24, 1'b1, 32'h000013, 24'hFFFFFF, 1'b0, 8'h00};
        vt[8]  = '{4'd3,  4'd3, 32'h123456, 24, 1'b1, 32'h01C0DE, 24'h000000, 1'b0, 8'h01};
        vt[9]  = '{4'd15, 4'd15, 32'h00000D, 4, 1'b1, 32'h00000A, 24'h000000, 1'b0, 8'h00};
        vt[10] = '{4'd4,  4'd7, 32'h777777, 24, 1'b1, 32'h02C0DE, 24'h000001, 1'b0, 8'h02};

        // Reset state, both during and after reset.
        step(); step();
        check("rst_addr", 256'(addr_out), 256'(0));
        check("rst_err", 256'(len_err), 256'(0));
        reset_n = 1'b1;
        step();
        check("rst_tdo", 256'(tdo), 256'(0));
        check("rst_strobe", 256'(upd_strobe), 256'(0));
        check("rst_data", 256'(upd_data_out), 256'(0));

        // Directed vector table.
        for (int v = 0; v < 11; v++) begin
            scan(vt[v].op, vt[v].ir_mid, 64'(vt[v].din), vt[v].nbits, vt[v].upd, dout, stb);
            check($sformatf("vec%0d_tdo", v), 256'(dout), 256'(vt[v].exp_tdo));
            check($sformatf("vec%0d_addr", v), 256'(addr_out), 256'(vt[v].exp_addr));
            check($sformatf("vec%0d_err", v), 256'(len_err), 256'(vt[v].exp_err));
            check($sformatf("vec%0d_strobe", v), 256'(stb), 256'(vt[v].exp_stb));
        end
        check("slice2_final", 256'(upd_data_out[2*DRL +: DRL]), 256'(24'h0000C3));
        check("slice5_untouched", 256'(upd_data_out[5*DRL +: DRL]), 256'(0));
        check("slice0_final", 256'(upd_data_out[0 +: DRL]), 256'(24'h123456));
        check("slice1_midscan_ir", 256'(upd_data_out[1*DRL +: DRL]), 256'(24'h777777));

        // Rejected STATUS write must not clear the flag even with sr[0]=1.
        scan(4'd6, 4'd6, 64'h3FF, 10, 1'b1, dout, stb);
        check("short_err", 256'(len_err), 256'(1));
        check("short_strobe", 256'(stb), 256'(0));
        scan(4'd2, 4'd2, 64'h1, 23, 1'b1, dout, stb);
        check("status_read", 256'(dout[0]), 256'(1));
        check("status_short_keeps", 256'(len_err), 256'(1));
        scan(4'd2, 4'd2, 64'h0, 24, 1'b1, dout, stb);
        check("status_zero_keeps", 256'(len_err), 256'(1));
        scan(4'd2, 4'd2, 64'h1, 24, 1'b1, dout, stb);
        check("status_clear", 256'(len_err), 256'(0));

        // Very long scan must not wrap the counter back to an accepted length.
        scan(4'd6, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 56, 1'b1, dout, stb);
        check("long_err", 256'(len_err), 256'(1));
        check("long_strobe", 256'(stb), 256'(0));
        check("long_slice3", 256'(upd_data_out[3*DRL +: DRL]), 256'(0));
        check("long_addr", 256'(addr_out), 256'(24'h000001));

        // Capture and shift together: capture wins, IDENT streams intact.
        ir = 4'd0; capture_dr = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
        step();
        capture_dr = 1'b0;
        dout = '0;
        for (int i = 0; i < DRL; i++) begin
            tdi = 1'b0;
            dout[i] = tdo;
            step();
        end
        shift_dr = 1'b0;
        step();
        check("cap_over_shift", 256'(dout), 256'(24'h4A5447));

        // Random scans against the model, from a fresh reset.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        m_addr = '0;
        m_err = 1'b0;
        for (int k = 0; k < NR; k++) m_data[k] = '0;
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < NR; k++) cap_data_in[k*DRL +: DRL] = 24'($urandom);
            op  = 4'($urandom_range(0, 15));
            mid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : op;
            r   = int'($urandom_range(0, 9));
            nb  = (r < 6) ? 24 : (r == 6) ? 23 : (r == 7) ? 25 : int'($urandom_range(0, 40));
            upd = ($urandom_range(0, 4) != 0);
            din = {32'($urandom), 32'($urandom)};
            if (op == 4'd2 && $urandom_range(0, 1) == 1) din[0] = 1'b1;
            model_scan(op, din, nb, upd, eout, estb);
            scan(op, mid, din, nb, upd, dout, stb);
            for (int k = 0; k < NR; k++) edata[k*DRL +: DRL] = m_data[k];
            check($sformatf("rnd%0d_tdo", n), 256'(dout), 256'(eout));
            check($sformatf("rnd%0d_strobe", n), 256'(stb), 256'(estb));
            check($sformatf("rnd%0d_addr", n), 256'(addr_out), 256'(m_addr));
            check($sformatf("rnd%0d_err", n), 256'(len_err), 256'(m_err));
            check($sformatf("rnd%0d_data", n), 256'(upd_data_out), 256'(edata));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
